// File: rtl/bp_fe_pkg.sv
// Shared front-end types: BE->FE command layout, opcodes and sequencer states.
package bp_fe_pkg;

    // Processor configurations; each one fixes the command layout below.
    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [3:0] {
        e_op_state_reset          = 4'd0,
        e_op_pc_redirection       = 4'd1,
        e_op_icache_fill_response = 4'd2,
        e_op_icache_fence         = 4'd3,
        e_op_itlb_fill_response   = 4'd4,
        e_op_itlb_fence           = 4'd5,
        e_op_attaboy              = 4'd6,
        e_op_wait                 = 4'd7
    } bp_fe_command_queue_opcode_e;

    typedef struct packed {
        bp_fe_command_queue_opcode_e opcode;
        logic [38:0]                 vaddr;
        logic [31:0]                 operands;
    } bp_fe_cmd_s;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_fence = 1'b1
    } bp_fe_cmd_seq_state_e;

    // Width of the packed command for a given processor configuration.
    function automatic int fe_cmd_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_fe_cmd_s);
            default:          return $bits(bp_fe_cmd_s);
        endcase
    endfunction

    // Opcode field of a packed command.
    function automatic bp_fe_command_queue_opcode_e cmd_opcode(bp_fe_cmd_s cmd);
        return cmd.opcode;
    endfunction

endpackage

// File: rtl/bp_fe_cmd_fifo.sv
// 1r1w command FIFO with registered full/empty flags and no fall-through.
// Caller guarantees v_i only when ~full_o and yumi_i only when ~empty_o.
module bp_fe_cmd_fifo #(
    parameter int width_p = 1,
    parameter int els_p   = 4,
    localparam int ptr_w_lp = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               full_o,
    output logic               empty_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic                full_q, full_d, empty_q, empty_d;

    // Next pointers and flags; the extra MSB is a wrap bit that separates full from empty.
    always_comb begin
        wptr_d  = wptr_q + {{ptr_w_lp{1'b0}}, v_i};
        rptr_d  = rptr_q + {{ptr_w_lp{1'b0}}, yumi_i};
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[ptr_w_lp] != rptr_d[ptr_w_lp])
                  && (wptr_d[ptr_w_lp-1:0] == rptr_d[ptr_w_lp-1:0]);
    end

    // Pointer and flag registers.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage write.
    // NOTE: the data array has no reset; empty_o guards every read of stale contents.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_q[wptr_q[ptr_w_lp-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q[ptr_w_lp-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/bp_fe_cmd_sequencer.sv
// Buffers BE->FE commands, releases them in order to FE decode, holds fetch while an
// icache fence is outstanding and discards attaboy hints rather than stall on them.
module bp_fe_cmd_sequencer
    import bp_fe_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int         cmd_fifo_els_p   = 4,
    parameter int         fence_timeout_p  = 1024,
    parameter int         drop_cnt_width_p = 16,
    localparam int        fe_cmd_width_lp  = fe_cmd_width(bp_params_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [fe_cmd_width_lp-1:0]  fe_cmd_i,
    input  logic                        fe_cmd_v_i,
    output logic                        fe_cmd_ready_o,
    output logic [fe_cmd_width_lp-1:0]  cmd_o,
    output logic                        cmd_v_o,
    input  logic                        cmd_yumi_i,
    input  logic                        fence_done_i,
    output logic                        fetch_hold_o,
    output logic                        fence_timeout_o,
    output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

    localparam int timer_w_lp = $clog2(fence_timeout_p + 1);
    localparam logic [timer_w_lp-1:0] timer_last_lp = timer_w_lp'(fence_timeout_p - 1);

    bp_fe_cmd_seq_state_e        state_q, state_d;
    logic [timer_w_lp-1:0]       timer_q, timer_d;
    logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;

    logic fifo_full, fifo_empty;
    logic in_is_attaboy, head_is_fence;
    logic push, pop, drop, timeout_hit;

    assign in_is_attaboy = (cmd_opcode(bp_fe_cmd_s'(fe_cmd_i)) == e_op_attaboy);
    assign head_is_fence = (cmd_opcode(bp_fe_cmd_s'(cmd_o)) == e_op_icache_fence);

    // Attaboys are always accepted; when full they are counted and thrown away.
    assign push = fe_cmd_v_i & ~fifo_full;
    assign drop = fe_cmd_v_i & fifo_full & in_is_attaboy;
    assign pop  = cmd_yumi_i & cmd_v_o;

    assign timeout_hit = (state_q == e_fence) & ~fence_done_i & (timer_q == timer_last_lp);

    // Outputs are masked by reset so they fall immediately on an asynchronous assert.
    assign fe_cmd_ready_o  = ~reset_i & (~fifo_full | in_is_attaboy);
    assign cmd_v_o         = ~reset_i & ~fifo_empty & (state_q == e_ready);
    assign fetch_hold_o    = ~reset_i & (state_q == e_fence);
    assign fence_timeout_o = ~reset_i & timeout_hit;
    assign drop_cnt_o      = drop_cnt_q;

    bp_fe_cmd_fifo #(
        .width_p (fe_cmd_width_lp),
        .els_p   (cmd_fifo_els_p)
    ) cmd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (fe_cmd_i),
        .v_i     (push),
        .data_o  (cmd_o),
        .yumi_i  (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Fence FSM, fence timer and saturating drop counter next-state.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            e_ready: begin
                if (pop && head_is_fence) begin
                    state_d = e_fence;
                    timer_d = '0;
                end
            end
            e_fence: begin
                if (fence_done_i || timeout_hit) begin
                    state_d = e_ready;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + timer_w_lp'(1);
                end
            end
            default: state_d = e_ready;
        endcase
        if (drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + drop_cnt_width_p'(1);
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_ready;
            timer_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FE may only consume a head that is being offered.
    yumi_without_valid_a: assert property (
        @(posedge clk_i) disable iff (reset_i) !(cmd_yumi_i && !cmd_v_o)
    ) else $error("cmd_yumi_i asserted while cmd_v_o is low");

endmodule
